fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Drives the program-memory side of the instruction fetch path.
- Holds the program counter and presents it as the ROM address.
- Waits a configurable ROM read latency, then pulses a one-cycle capture enable so the instruction register latches the 8-bit ROM byte (opcode nibble and operand nibble).
- Alternates FETCH and EXECUTE phases for the rest of the core and accepts branch loads of the PC during EXECUTE.

Parameters:
- ADDR_W, 12, width of the program counter and ROM address.
- ROM_LAT, 1, cycles from a stable rom_addr to valid rom_data. Legal range 1..7.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- run  in  1  level; 1 = keep fetching, 0 = stop after the current instruction completes.
- load_pc  in  1  branch request; sampled only in EXEC.
- load_addr  in  ADDR_W  branch target.
- rom_data  in  8  ROM output byte; must be valid ROM_LAT cycles after rom_addr changes.
- rom_addr  out  ADDR_W  registered address to the ROM; equals pc.
- fetch_en  out  1  one-cycle pulse; enable for the instruction register.
- phase  out  1  0 = fetch phase (ADDR/WAIT/CAPTURE), 1 = EXEC.
- busy  out  1  1 in every state except IDLE.
- pc  out  ADDR_W  current program counter.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - pc=0, rom_addr=0, fetch_en=0, phase=0, busy=0, wait counter=0.
  - Reset asserted mid-fetch aborts immediately. No fetch_en pulse is produced, and the PC is not incremented.
- IDLE: if run=1, go to ADDR next cycle; otherwise stay.
- ADDR:
  - rom_addr holds pc.
  - Load wait counter with ROM_LAT-1.
  - If ROM_LAT=1, go to CAPTURE; otherwise go to WAIT.
- WAIT: decrement counter each cycle; go to CAPTURE when the counter reaches 0. Total ADDR+WAIT cycles = ROM_LAT.
- CAPTURE:
  - fetch_en=1 for exactly this cycle.
  - rom_data is valid during this cycle; the instruction register captures it at the closing edge.
  - pc <= pc+1 at the same edge.
  - rom_addr stays at the old pc for the whole cycle and is not updated until the next ADDR.
  - Go to EXEC.
- EXEC:
  - phase=1 for exactly one cycle.
  - If load_pc=1, then pc <= load_addr at the closing edge, overriding the already-incremented value.
  - Next state: if run=1, go to ADDR; otherwise go to IDLE.
- Instruction period = ROM_LAT+2 cycles. fetch_en pulses are spaced exactly ROM_LAT+2 cycles apart while run=1.
- Boundary conditions:
  - PC wrap: pc = 2^ADDR_W-1 increments to 0 with no flag.
  - run dropped during ADDR/WAIT/CAPTURE: the fetch completes, including the fetch_en pulse and EXEC, then the block goes to IDLE.
  - run dropped during EXEC: the block goes to IDLE.
  - load_pc outside EXEC: ignored, no pending state.
  - load_pc=1 and run=0 in EXEC: the load is taken; the next fetch after run returns uses load_addr.
  - load_addr equal to the current pc: legal; the same instruction is refetched.
- fetch_en, phase, busy and rom_addr are all registered outputs (glitch-free).
- The instruction register uses an active-high reset, so the top level drives it with ~reset.

Decomposition:
- Shared package core_pkg:
  - state encoding localparams S_IDLE=0, S_ADDR=1, S_WAIT=2, S_CAPT=3, S_EXEC=4 (3-bit).
  - PHASE_FETCH=0, PHASE_EXEC=1.
  - Default ADDR_W.
- One natural sub-module: pc_reg, an ADDR_W-bit register with async active-low reset, increment enable and parallel load (load has priority). It is reused by the stack/call logic later.
- The FSM and latency counter stay in fetch_sequencer.

Test Plan:
- Reset then run=1, ROM_LAT=1:
  - fetch_en high on cycles 2, 5, 8 after reset release.
  - rom_addr = 0, 1, 2 during those pulses.
  - phase=1 on cycles 3, 6, 9.
- ROM_LAT=3, ROM model returns byte = addr[7:0]^8'hA5: each fetch_en cycle sees rom_data = 8'hA5, 8'hA4, 8'hA7; period = 5 cycles.
- load_pc=1 with load_addr=12'h3F0 during EXEC of instruction at pc=4: next rom_addr = 3F0; pc goes 4 -> 5 -> 3F0.
- load_pc pulsed during CAPTURE only: ignored; next rom_addr = old pc+1.
- Preset pc to 12'hFFF via load, run=1: after fetching FFF, next rom_addr = 000.
- run dropped in WAIT (ROM_LAT=3): one more fetch_en, one EXEC cycle, then busy=0.
- Reset asserted in WAIT: outputs go to 0 immediately, no fetch_en pulse, and pc=0 on release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core: FSM state encoding, phase values
// and the default program-counter width.
package core_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_EXEC = 3'd4
  } state_t;

  localparam logic PHASE_FETCH = 1'b0;
  localparam logic PHASE_EXEC  = 1'b1;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-path bundle between the core control, the program ROM and the sequencer.
interface fetch_sequencer_if
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);
  logic              run;
  logic              load_pc;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              fetch_en;
  logic              phase;
  logic              busy;
  logic [ADDR_W-1:0] pc;

  modport master (
    output run, load_pc, load_addr, rom_data,
    input  rom_addr, fetch_en, phase, busy, pc
  );

  modport slave (
    input  run, load_pc, load_addr, rom_data,
    output rom_addr, fetch_en, phase, busy, pc
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset, increment enable and
// parallel load, with load taking priority over increment.
module pc_reg
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + ONE;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: presents pc to the ROM, waits out the ROM latency,
// pulses fetch_en for the instruction register, then spends one EXEC cycle.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);
  localparam logic [2:0] LAT_M1 = 3'(ROM_LAT - 1);

  state_t            state;
  logic [2:0]        wait_cnt;
  logic              pc_inc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_q;

  assign pc_inc  = (state == S_CAPT);
  assign pc_load = (state == S_EXEC) && bus.load_pc;

  pc_reg #(.ADDR_W(ADDR_W)) u_pc (
    .clk       (clk),
    .reset     (reset),
    .inc       (pc_inc),
    .load      (pc_load),
    .load_addr (bus.load_addr),
    .pc        (pc_q)
  );

  assign bus.pc = pc_q;

  // Outputs are set on the edge entering each state so they are all registered.
  // rom_addr follows the pc value that pc_reg will hold after the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      bus.rom_addr <= '0;
      bus.fetch_en <= 1'b0;
      bus.phase    <= PHASE_FETCH;
      bus.busy     <= 1'b0;
    end else begin
      bus.fetch_en <= 1'b0;
      bus.phase    <= PHASE_FETCH;
      unique case (state)
        S_IDLE: begin
          if (bus.run) begin
            state        <= S_ADDR;
            bus.rom_addr <= pc_q;
            bus.busy     <= 1'b1;
          end
        end
        S_ADDR: begin
          wait_cnt <= LAT_M1;
          if (ROM_LAT == 1) begin
            state        <= S_CAPT;
            bus.fetch_en <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state        <= S_CAPT;
            bus.fetch_en <= 1'b1;
          end
        end
        S_CAPT: begin
          state     <= S_EXEC;
          bus.phase <= PHASE_EXEC;
        end
        S_EXEC: begin
          if (bus.run) begin
            state        <= S_ADDR;
            bus.rom_addr <= bus.load_pc ? bus.load_addr : pc_q;
          end else begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a cycle table at ROM_LAT=1, directed latency/reset
// sequences at ROM_LAT=3, and random run/branch traffic against a reference model.
module tb_fetch_sequencer;
  import core_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  fetch_sequencer_if #(.ADDR_W(AW)) bus_a ();
  fetch_sequencer_if #(.ADDR_W(AW)) bus_b ();

  fetch_sequencer #(.ADDR_W(AW), .ROM_LAT(LAT_A)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  fetch_sequencer #(.ADDR_W(AW), .ROM_LAT(LAT_B)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  // ROM: byte = addr[7:0] ^ A5, valid LAT edges after the address was presented
  logic [AW-1:0] hist_a [8];
  logic [AW-1:0] hist_b [8];
  always @(posedge clk) begin
    hist_a[0] <= bus_a.rom_addr;
    hist_b[0] <= bus_b.rom_addr;
    for (int i = 1; i < 8; i++) begin
      hist_a[i] <= hist_a[i-1];
      hist_b[i] <= hist_b[i-1];
    end
  end
  assign bus_a.rom_data = hist_a[LAT_A-1][7:0] ^ 8'hA5;
  assign bus_b.rom_data = hist_b[LAT_B-1][7:0] ^ 8'hA5;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          run;
    logic          load_pc;
    logic [AW-1:0] load_addr;
    logic          fe;
    logic          ph;
    logic          busy;
    logic [AW-1:0] addr;
    logic [AW-1:0] pc;
  } vec_t;

  function automatic vec_t mk(logic r, logic lp, logic [AW-1:0] la,
                              logic fe, logic ph, logic b,
                              logic [AW-1:0] a, logic [AW-1:0] p);
    vec_t v;
    v.run = r; v.load_pc = lp; v.load_addr = la;
    v.fe = fe; v.ph = ph; v.busy = b; v.addr = a; v.pc = p;
    return v;
  endfunction

  // Reference model: position within the instruction (0..LAT+1) plus pc arithmetic
  int m_act  [2];
  int m_p    [2];
  int m_pc   [2];
  int m_addr [2];

  function automatic int lat_of(int k);
    return (k == 0) ? int'(LAT_A) : int'(LAT_B);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_p[k] = 0; m_pc[k] = 0; m_addr[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic r, input logic lp, input int la);
    int l;
    l = lat_of(k);
    if (m_act[k] == 0) begin
      if (r) begin
        m_act[k] = 1; m_p[k] = 0; m_addr[k] = m_pc[k];
      end
    end else if (m_p[k] == l + 1) begin
      if (lp) m_pc[k] = la;
      if (r) begin
        m_p[k] = 0; m_addr[k] = m_pc[k];
      end else begin
        m_act[k] = 0;
      end
    end else begin
      if (m_p[k] == l) m_pc[k] = (m_pc[k] + 1) % (1 << AW);
      m_p[k]++;
    end
  endtask

  task automatic model_check(input int k, input logic fe, input logic ph, input logic b,
                             input logic [AW-1:0] a, input logic [AW-1:0] p, input logic [7:0] rd);
    int efe, eph;
    string tag;
    tag = (k == 0) ? "rnd.a" : "rnd.b";
    efe = (m_act[k] != 0 && m_p[k] == lat_of(k)) ? 1 : 0;
    eph = (m_act[k] != 0 && m_p[k] == lat_of(k) + 1) ? 1 : 0;
    check({tag, ".fetch_en"}, 32'(fe), efe);
    check({tag, ".phase"},    32'(ph), eph);
    check({tag, ".busy"},     32'(b),  m_act[k]);
    check({tag, ".rom_addr"}, 32'(a),  m_addr[k]);
    check({tag, ".pc"},       32'(p),  m_pc[k]);
    if (efe != 0) check({tag, ".rom_data"}, 32'(rd), (m_addr[k] & 255) ^ 32'hA5);
  endtask

  vec_t tbl [28];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int npulse, cyc, fe_cnt, ph_cnt;
    int pulse_cyc [4];
    logic [7:0] pulse_dat [4];
    logic r, lp;
    logic [AW-1:0] la;
    int sel;

    tbl[0]  = mk(1, 0, 12'h000, 0, 0, 0, 12'h000, 12'h000);
    tbl[1]  = mk(1, 0, 12'h000, 0, 0, 1, 12'h000, 12'h000);
    tbl[2]  = mk(1, 0, 12'h000, 1, 0, 1, 12'h000, 12'h000);
    tbl[3]  = mk(1, 0, 12'h000, 0, 1, 1, 12'h000, 12'h001);
    tbl[4]  = mk(1, 0, 12'h000, 0, 0, 1, 12'h001, 12'h001);
    tbl[5]  = mk(1, 1, 12'h3F0, 1, 0, 1, 12'h001, 12'h001);
    tbl[6]  = mk(1, 0, 12'h000, 0, 1, 1, 12'h001, 12'h002);
    tbl[7]  = mk(1, 0, 12'h000, 0, 0, 1, 12'h002, 12'h002);
    tbl[8]  = mk(1, 0, 12'h000, 1, 0, 1, 12'h002, 12'h002);
    tbl[9]  = mk(1, 0, 12'h000, 0, 1, 1, 12'h002, 12'h003);
    tbl[10] = mk(1, 0, 12'h000, 0, 0, 1, 12'h003, 12'h003);
    tbl[11] = mk(1, 0, 12'h000, 1, 0, 1, 12'h003, 12'h003);
    tbl[12] = mk(1, 0, 12'h000, 0, 1, 1, 12'h003, 12'h004);
    tbl[13] = mk(1, 0, 12'h000, 0, 0, 1, 12'h004, 12'h004);
    tbl[14] = mk(1, 0, 12'h000, 1, 0, 1, 12'h004, 12'h004);
    tbl[15] = mk(1, 1, 12'h3F0, 0, 1, 1, 12'h004, 12'h005);
    tbl[16] = mk(1, 0, 12'h000, 0, 0, 1, 12'h3F0, 12'h3F0);
    tbl[17] = mk(1, 0, 12'h000, 1, 0, 1, 12'h3F0, 12'h3F0);
    tbl[18] = mk(0, 1, 12'hFFF, 0, 1, 1, 12'h3F0, 12'h3F1);
    tbl[19] = mk(0, 0, 12'h000, 0, 0, 0, 12'h3F0, 12'hFFF);
    tbl[20] = mk(1, 0, 12'h000, 0, 0, 0, 12'h3F0, 12'hFFF);
    tbl[21] = mk(1, 0, 12'h000, 0, 0, 1, 12'hFFF, 12'hFFF);
    tbl[22] = mk(1, 0, 12'h000, 1, 0, 1, 12'hFFF, 12'hFFF);
    tbl[23] = mk(1, 0, 12'h000, 0, 1, 1, 12'hFFF, 12'h000);
    tbl[24] = mk(1, 0, 12'h000, 0, 0, 1, 12'h000, 12'h000);
    tbl[25] = mk(0, 0, 12'h000, 1, 0, 1, 12'h000, 12'h000);
    tbl[26] = mk(0, 0, 12'h000, 0, 1, 1, 12'h000, 12'h001);
    tbl[27] = mk(0, 0, 12'h000, 0, 0, 0, 12'h000, 12'h001);

    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.run = 1'b0; bus_a.load_pc = 1'b0; bus_a.load_addr = '0;
    bus_b.run = 1'b0; bus_b.load_pc = 1'b0; bus_b.load_addr = '0;
    for (int i = 0; i < 4; i++) begin
      pulse_cyc[i] = 0; pulse_dat[i] = 8'h00;
    end
    repeat (3) @(negedge clk);

    // ROM_LAT=1 cycle table; entry i is cycle i after reset release
    bus_a.run = tbl[0].run;
    rst_a = 1'b1;
    for (int i = 0; i < 28; i++) begin
      check($sformatf("tbl%0d.fetch_en", i), 32'(bus_a.fetch_en), 32'(tbl[i].fe));
      check($sformatf("tbl%0d.phase", i),    32'(bus_a.phase),    32'(tbl[i].ph));
      check($sformatf("tbl%0d.busy", i),     32'(bus_a.busy),     32'(tbl[i].busy));
      check($sformatf("tbl%0d.rom_addr", i), 32'(bus_a.rom_addr), 32'(tbl[i].addr));
      check($sformatf("tbl%0d.pc", i),       32'(bus_a.pc),       32'(tbl[i].pc));
      if (tbl[i].fe)
        check($sformatf("tbl%0d.rom_data", i), 32'(bus_a.rom_data), 32'(tbl[i].addr[7:0] ^ 8'hA5));
      bus_a.run       = tbl[i].run;
      bus_a.load_pc   = tbl[i].load_pc;
      bus_a.load_addr = tbl[i].load_addr;
      @(negedge clk);
    end
    rst_a = 1'b0;

    // ROM_LAT=3: pulse timing and data
    bus_b.run = 1'b1;
    rst_b = 1'b1;
    npulse = 0; cyc = 0;
    while (npulse < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus_b.fetch_en) begin
        pulse_cyc[npulse] = cyc;
        pulse_dat[npulse] = bus_b.rom_data;
        npulse++;
      end
    end
    check("lat3.pulse_count", npulse, 3);
    check("lat3.pulse0_cycle", pulse_cyc[0], 4);
    check("lat3.pulse1_cycle", pulse_cyc[1], 9);
    check("lat3.pulse2_cycle", pulse_cyc[2], 14);
    check("lat3.data0", 32'(pulse_dat[0]), 32'hA5);
    check("lat3.data1", 32'(pulse_dat[1]), 32'hA4);
    check("lat3.data2", 32'(pulse_dat[2]), 32'hA7);

    // run dropped in WAIT: this fetch finishes, then idle
    repeat (3) @(negedge clk);
    check("lat3.in_wait_busy", 32'(bus_b.busy), 1);
    bus_b.run = 1'b0;
    fe_cnt = 0; ph_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_b.fetch_en) begin
        fe_cnt++;
        check("lat3.drop_data", 32'(bus_b.rom_data), 32'hA6);
      end
      if (bus_b.phase) ph_cnt++;
    end
    check("lat3.drop_fe_count", fe_cnt, 1);
    check("lat3.drop_ph_count", ph_cnt, 1);
    check("lat3.drop_busy", 32'(bus_b.busy), 0);
    check("lat3.drop_pc", 32'(bus_b.pc), 4);

    // Reset asserted in WAIT aborts at once
    bus_b.run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstwait.pre_busy", 32'(bus_b.busy), 1);
    check("rstwait.pre_addr", 32'(bus_b.rom_addr), 4);
    rst_b = 1'b0;
    #1;
    check("rstwait.fetch_en", 32'(bus_b.fetch_en), 0);
    check("rstwait.phase", 32'(bus_b.phase), 0);
    check("rstwait.busy", 32'(bus_b.busy), 0);
    check("rstwait.rom_addr", 32'(bus_b.rom_addr), 0);
    check("rstwait.pc", 32'(bus_b.pc), 0);
    bus_b.run = 1'b0;
    fe_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_b.fetch_en) fe_cnt++;
    end
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_b.fetch_en) fe_cnt++;
    end
    check("rstwait.no_pulse", fe_cnt, 0);
    check("rstwait.pc_release", 32'(bus_b.pc), 0);
    check("rstwait.busy_release", 32'(bus_b.busy), 0);

    // Random run/branch traffic on both latencies against the model
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    model_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 9) != 0);
      lp  = ($urandom_range(0, 3) == 0);
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      la = 12'hFFF;
      else if (sel == 1) la = AW'(m_pc[0]);
      else               la = AW'($urandom);
      bus_a.run = r; bus_a.load_pc = lp; bus_a.load_addr = la;
      bus_b.run = r; bus_b.load_pc = lp; bus_b.load_addr = la;
      @(posedge clk);
      model_step(0, r, lp, int'(la));
      model_step(1, r, lp, int'(la));
      @(negedge clk);
      model_check(0, bus_a.fetch_en, bus_a.phase, bus_a.busy, bus_a.rom_addr, bus_a.pc, bus_a.rom_data);
      model_check(1, bus_b.fetch_en, bus_b.phase, bus_b.busy, bus_b.rom_addr, bus_b.pc, bus_b.rom_data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
